// File: rtl/sha256_cs_resolver.sv
// rtl/sha256_cs_resolver.sv - iterative carry-save to binary resolver, CHUNK bits per cycle
// Optional out_carry port (MSB carry of the final chunk) enabled by CS_CARRY_OUT_EN.
module sha256_cs_resolver #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vs,
   input  logic [WIDTH-1:0] in_vc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum
`ifdef CS_CARRY_OUT_EN
   ,
   output logic             out_carry
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t                       state_q, state_d;
   logic [NCHUNK-1:0][CHUNK-1:0] vs_q, vc_q, sum_q;
   logic [CW-1:0]                cnt_q;
   logic                         carry_q;
   logic [CHUNK-1:0]             vs_sel, vc_sel;
   logic [CHUNK:0]               chunk_sum;
   logic                         last_chunk;

   // Chunk select written as a compare loop so CHUNK == WIDTH needs no special case.
   always_comb begin
      vs_sel = '0;
      vc_sel = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt_q == CW'(i)) begin
            vs_sel = vs_q[i];
            vc_sel = vc_q[i];
         end
      end
      chunk_sum  = {1'b0, vs_sel} + {1'b0, vc_sel} + {{CHUNK{1'b0}}, carry_q};
      last_chunk = (cnt_q == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ADD;
         end
         ADD: begin
            if (last_chunk) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q    <= '0;
         vc_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else if (state_q == IDLE) begin
         if (in_valid) begin
            vs_q    <= in_vs;
            vc_q    <= in_vc;
            cnt_q   <= '0;
            carry_q <= 1'b0;
         end
      end else if (state_q == ADD) begin
         for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) sum_q[i] <= chunk_sum[CHUNK-1:0];
         end
         carry_q <= chunk_sum[CHUNK];
         cnt_q   <= cnt_q + CW'(1);
      end
   end

   assign out_sum = sum_q;

`ifdef CS_CARRY_OUT_EN
   logic carry_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          carry_out_q <= 1'b0;
      else if (state_q == ADD && last_chunk) carry_out_q <= chunk_sum[CHUNK];
   end

   assign out_carry = carry_out_q;
`endif

endmodule

// File: tb/tb_sha256_cs_resolver.sv
// tb/tb_sha256_cs_resolver.sv - self-checking bench for sha256_cs_resolver (CS_CARRY_OUT_EN aware)
module tb_sha256_cs_resolver;

   localparam int WIDTH  = 32;
   parameter  int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int NSTREAM = 1000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_vs;
   logic [WIDTH-1:0] in_vc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
`ifdef CS_CARRY_OUT_EN
   logic             out_carry;
`endif

   int checks = 0;
   int errors = 0;

   sha256_cs_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vs     (in_vs),
      .in_vc     (in_vc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
`ifdef CS_CARRY_OUT_EN
      ,
      .out_carry (out_carry)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer addition, bit WIDTH is the carry out of the MSB.
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic check_result(input string tag, input logic [WIDTH:0] r);
      check({tag, "_sum"}, out_sum, r[WIDTH-1:0]);
`ifdef CS_CARRY_OUT_EN
      check({tag, "_carry"}, out_carry, r[WIDTH]);
`endif
   endtask

   // Full transaction from IDLE; garbage is held on the input side while busy.
   task automatic do_txn(input string tag, input logic [WIDTH-1:0] vs, input logic [WIDTH-1:0] vc);
      logic [WIDTH:0] r;
      int lat;
      int busy_ready;
      r = ref_add(vs, vc);
      check({tag, "_idle_ready"}, in_ready, 1'b1);
      in_valid  = 1'b1;
      in_vs     = vs;
      in_vc     = vc;
      out_ready = 1'b1;
      tick();
      in_vs = $urandom;
      in_vc = $urandom;
      lat = 0;
      busy_ready = 0;
      while (!out_valid && lat < 64) begin
         if (in_ready) busy_ready++;
         tick();
         lat++;
      end
      if (in_ready) busy_ready++;
      in_valid = 1'b0;
      check({tag, "_latency"}, lat, NCHUNK);
      check({tag, "_busy_in_ready"}, busy_ready, 0);
      check_result(tag, r);
      tick();
      check({tag, "_drain_valid"}, out_valid, 1'b0);
      check({tag, "_drain_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [WIDTH:0]   r;
      logic [WIDTH:0]   e;
      logic [WIDTH-1:0] held_sum;
      logic [WIDTH-1:0] nvs, nvc;
      logic [WIDTH:0]   expq[$];
      int               lat, sent, recv, cyc, bad;
      logic             acc, fire;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vs     = '0;
      in_vc     = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_sum", out_sum, '0);
`ifdef CS_CARRY_OUT_EN
      check("reset_out_carry", out_carry, 1'b0);
`endif
      rst_n = 1'b1;
      tick();

      do_txn("basic", 32'h12345678, 32'h11111110);
      check("basic_const", out_sum, 32'h23456788);
      do_txn("ripple", 32'hFFFFFFFF, 32'h00000001);
      do_txn("wrap", 32'h80000000, 32'h80000000);
      do_txn("nowrap", 32'h00FF00FF, 32'h00010001);
      check("nowrap_const", out_sum, 32'h01000100);

      // Output stall with a competing input request.
      nvs = $urandom;
      nvc = $urandom;
      r = ref_add(nvs, nvc);
      in_valid = 1'b1; in_vs = nvs; in_vc = nvc; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin tick(); lat++; end
      check("stall_latency", lat, NCHUNK);
      check_result("stall", r);
      held_sum = out_sum;
      nvs = $urandom;
      nvc = $urandom;
      in_valid = 1'b1; in_vs = nvs; in_vc = nvc;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_sum !== held_sum || in_ready !== 1'b0) bad++;
      end
      check("stall_stable", bad, 0);
      out_ready = 1'b1;
      tick();
      check("stall_release_valid", out_valid, 1'b0);
      check("stall_release_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      check("stall_next_accepted", in_ready, 1'b0);
      lat = 0;
      while (!out_valid && lat < 64) begin tick(); lat++; end
      check("stall_next_latency", lat, NCHUNK);
      check_result("stall_next", ref_add(nvs, nvc));
      tick();

      // Reset during the second ADD cycle aborts the operation.
      in_valid = 1'b1; in_vs = $urandom; in_vc = $urandom; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_out_sum", out_sum, '0);
      check("abort_in_ready", in_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < NCHUNK + 3; i++) begin
         tick();
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      check("abort_no_result", bad, 0);
      do_txn("after_abort", 32'h6A09E667, 32'hBB67AE85);
      check("after_abort_const", out_sum, 32'h257194EC);

      // Random stream with random output stalls, checked in order against a queue.
      sent = 0; recv = 0; cyc = 0;
      in_valid = 1'b0;
      while (recv < NSTREAM && cyc < 60000) begin
         if (!in_valid && sent < NSTREAM && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_vs    = $urandom;
            in_vc    = $urandom;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         acc  = in_valid && in_ready;
         fire = out_valid && out_ready;
         if (fire) begin
            if (expq.size() == 0) begin
               check("stream_spurious", 1'b1, 1'b0);
            end else begin
               e = expq.pop_front();
               check_result("stream", e);
            end
            recv++;
         end
         if (acc) begin
            expq.push_back(ref_add(in_vs, in_vc));
            sent++;
         end
         tick();
         cyc++;
         if (acc) in_valid = 1'b0;
      end
      check("stream_count", recv, NSTREAM);
      check("stream_leftover", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
